// File: rtl/sobel_stream.sv
// sobel_stream: streaming 3x3 Sobel edge detector.
// Takes one grayscale pixel per i_valid cycle in raster order and builds the
// 3x3 window from two internal line buffers. Every accepted pixel produces
// exactly one output three clocks later: a thresholded edge bit and,
// in magnitude mode, the |Gx|+|Gy| gradient magnitude.
// Ports:
//   clk, reset          - rising-edge clock, asynchronous active-high reset
//   i_valid, i_sof      - pixel strobe (no backpressure), start of frame
//   i_data              - unsigned gray pixel
//   i_threshold         - edge threshold, latched on a valid start of frame
//   i_mode              - 0 = binary edge (o_mag forced 0), 1 = magnitude
//   o_valid, o_sof      - output strobe and frame marker, 3 cycles after input
//   o_edge, o_mag       - edge flag (mag > threshold) and gradient magnitude
module sobel_stream #(
  parameter int DATA_W         = 8,
  parameter int IMG_W          = 320,
  parameter int IMG_H          = 240,
  parameter int THRESH_DEFAULT = 500,
  localparam int MAG_W         = DATA_W + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  logic              i_sof,
  input  logic [DATA_W-1:0] i_data,
  input  logic [MAG_W-1:0]  i_threshold,
  input  logic              i_mode,
  output logic              o_valid,
  output logic              o_sof,
  output logic              o_edge,
  output logic [MAG_W-1:0]  o_mag
);

  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [MAG_W-1:0] THR_RST = MAG_W'(THRESH_DEFAULT);

  // Zero-extend a pixel into the signed gradient width.
  function automatic logic signed [MAG_W:0] ext(input logic [DATA_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  logic              sof_hit;
  logic [COL_W-1:0]  cur_col, col_d, col_q;
  logic [ROW_W-1:0]  cur_row, row_d, row_q;
  logic [MAG_W-1:0]  thr_d, thr_q;

  logic [DATA_W-1:0] lb0_mem [IMG_W];
  logic [DATA_W-1:0] lb1_mem [IMG_W];
  logic [DATA_W-1:0] lb0_rd, lb1_rd;

  // win[row][col]: row 0 = two lines up, col 0 = oldest column
  logic [DATA_W-1:0] win_d [3][3];
  logic [DATA_W-1:0] win_q [3][3];
  logic              s1_valid_d, s1_valid_q, s1_sof_d, s1_sof_q;
  logic              s1_mask_d, s1_mask_q;
  logic [MAG_W-1:0]  s1_thr_d, s1_thr_q;

  logic signed [MAG_W:0] gx_d, gx_q, gy_d, gy_q;
  logic              s2_valid_q, s2_sof_q, s2_mask_q;
  logic [MAG_W-1:0]  s2_thr_q;

  logic [MAG_W-1:0]  abs_x, abs_y, mag_sum;
  logic              out_valid_d, out_valid_q, out_sof_d, out_sof_q;
  logic              out_edge_d, out_edge_q;
  logic [MAG_W-1:0]  out_mag_d, out_mag_q;

  // Coordinate tracking. A valid sof pins the current pixel to (0,0), so a
  // mid-frame sof resynchronises without waiting for the counters to wrap.
  // The threshold is captured on that same pixel and travels with it.
  always_comb begin
    sof_hit = i_valid && i_sof;
    cur_col = sof_hit ? '0 : col_q;
    cur_row = sof_hit ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    thr_d   = sof_hit ? i_threshold : thr_q;
    if (i_valid) begin
      if (cur_col == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (cur_row == ROW_W'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end else begin
        col_d = cur_col + 1'b1;
        row_d = cur_row;
      end
    end
  end

  assign lb0_rd = lb0_mem[cur_col];
  assign lb1_rd = lb1_mem[cur_col];

  // Line buffers are plain storage without reset; whatever they hold before
  // two full rows have passed is hidden by the border mask.
  always_ff @(posedge clk) begin
    if (i_valid) begin
      lb0_mem[cur_col] <= i_data;
      lb1_mem[cur_col] <= lb0_rd;
    end
  end

  // Stage 1: shift the window by one column and capture per-pixel tags.
  always_comb begin
    win_d = win_q;
    if (i_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb1_rd;
      win_d[1][2] = lb0_rd;
      win_d[2][2] = i_data;
    end
    s1_valid_d = i_valid;
    s1_sof_d   = sof_hit;
    s1_mask_d  = (cur_row < ROW_W'(2)) || (cur_col < COL_W'(2));
    s1_thr_d   = thr_d;
  end

  // Stage 2: signed gradients, right-minus-left and top-minus-bottom.
  always_comb begin
    gx_d = gx_q;
    gy_d = gy_q;
    if (s1_valid_q) begin
      gx_d = (ext(win_q[0][2]) + (ext(win_q[1][2]) <<< 1) + ext(win_q[2][2]))
           - (ext(win_q[0][0]) + (ext(win_q[1][0]) <<< 1) + ext(win_q[2][0]));
      gy_d = (ext(win_q[0][0]) + (ext(win_q[0][1]) <<< 1) + ext(win_q[0][2]))
           - (ext(win_q[2][0]) + (ext(win_q[2][1]) <<< 1) + ext(win_q[2][2]));
    end
  end

  // Stage 3: magnitude, compare, border mask. Data outputs hold between strobes.
  always_comb begin
    abs_x       = gx_q[MAG_W] ? MAG_W'(-gx_q) : MAG_W'(gx_q);
    abs_y       = gy_q[MAG_W] ? MAG_W'(-gy_q) : MAG_W'(gy_q);
    mag_sum     = abs_x + abs_y;
    out_valid_d = s2_valid_q;
    out_sof_d   = s2_valid_q && s2_sof_q;
    out_edge_d  = out_edge_q;
    out_mag_d   = out_mag_q;
    if (s2_valid_q) begin
      out_edge_d = !s2_mask_q && (mag_sum > s2_thr_q);
      out_mag_d  = (s2_mask_q || !i_mode) ? '0 : mag_sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      thr_q       <= THR_RST;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win_q[r][c] <= '0;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_mask_q   <= 1'b0;
      s1_thr_q    <= '0;
      gx_q        <= '0;
      gy_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_mask_q   <= 1'b0;
      s2_thr_q    <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_edge_q  <= 1'b0;
      out_mag_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      thr_q       <= thr_d;
      win_q       <= win_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_mask_q   <= s1_mask_d;
      s1_thr_q    <= s1_thr_d;
      gx_q        <= gx_d;
      gy_q        <= gy_d;
      s2_valid_q  <= s1_valid_q;
      s2_sof_q    <= s1_sof_q;
      s2_mask_q   <= s1_mask_q;
      s2_thr_q    <= s1_thr_q;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_edge_q  <= out_edge_d;
      out_mag_q   <= out_mag_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_sof   = out_sof_q;
  assign o_edge  = out_edge_q;
  assign o_mag   = out_mag_q;

endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: scoreboard bench for sobel_stream on a small 8x6 image.
// The driver keeps an image array and frame coordinates, computes the expected
// output of each pixel from its 3x3 neighbourhood and queues it; the monitor
// pops and compares whenever o_valid is seen.
module tb_sobel_stream;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int DW   = 8;
  localparam int MW   = DW + 3;
  localparam int TDEF = 500;
  localparam int K_FLAT = 0, K_STEP = 1, K_RAND = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0, i_sof = 1'b0, i_mode = 1'b1;
  logic [DW-1:0] i_data = '0;
  logic [MW-1:0] i_threshold = '0;
  logic          o_valid, o_sof, o_edge;
  logic [MW-1:0] o_mag;

  sobel_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H), .THRESH_DEFAULT(TDEF)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_sof(i_sof),
    .i_data(i_data), .i_threshold(i_threshold), .i_mode(i_mode),
    .o_valid(o_valid), .o_sof(o_sof), .o_edge(o_edge), .o_mag(o_mag));

  always #5 clk = ~clk;

  typedef struct { bit sof; bit e; int mag; } exp_t;
  exp_t sbq[$];
  exp_t ex;

  int n_cmp = 0, n_bad = 0;
  int edge_cnt = 0, mag_max = 0;
  int last_e = 0, last_mag = 0;
  int img [H][W];
  int m_col = 0, m_row = 0, m_thr = TDEF;
  bit m_mode = 1'b1;
  logic [2:0] vhist = '0, shist = '0;

  task automatic checkOutput(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Three-deep record of accepted strobes: o_valid/o_sof must replay them.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vhist <= '0;
      shist <= '0;
    end else begin
      vhist <= {vhist[1:0], i_valid};
      shist <= {shist[1:0], i_valid && i_sof};
    end
  end

  // Monitor: pop and compare on every output strobe, check holds otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("o_valid_latency", o_valid, vhist[2]);
      checkOutput("o_sof_latency", o_sof, shist[2]);
      if (o_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          ex = sbq.pop_front();
          checkOutput("sof", o_sof, ex.sof);
          checkOutput("edge", o_edge, ex.e);
          checkOutput("mag", o_mag, ex.mag);
          last_e   = ex.e;
          last_mag = ex.mag;
          edge_cnt += o_edge;
          if (o_mag > mag_max) mag_max = o_mag;
        end
      end else begin
        checkOutput("hold_edge", o_edge, last_e);
        checkOutput("hold_mag", o_mag, last_mag);
      end
    end
  end

  function automatic int pix(input int kind, input int r, input int c);
    if (kind == K_FLAT) return 128;
    if (kind == K_STEP) return (c >= 5) ? 255 : 0;
    return int'($urandom_range(255));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Drive one pixel (after optional random idle cycles) and queue its result.
  task automatic applyStimulus(input int data, input bit sof, input int thr, input int gap_pct);
    int gx, gy, mag;
    bit e;
    while (int'($urandom_range(99)) < gap_pct) begin
      i_valid = 1'b0;
      i_sof = 1'($urandom_range(1));
      i_data = DW'($urandom);
      i_threshold = MW'($urandom);
      @(posedge clk); #1;
    end
    if (sof) begin
      m_col = 0;
      m_row = 0;
      m_thr = thr;
    end
    img[m_row][m_col] = data;
    mag = 0;
    e = 1'b0;
    if (m_row >= 2 && m_col >= 2) begin
      gx = (img[m_row-2][m_col] + 2*img[m_row-1][m_col] + img[m_row][m_col])
         - (img[m_row-2][m_col-2] + 2*img[m_row-1][m_col-2] + img[m_row][m_col-2]);
      gy = (img[m_row-2][m_col-2] + 2*img[m_row-2][m_col-1] + img[m_row-2][m_col])
         - (img[m_row][m_col-2] + 2*img[m_row][m_col-1] + img[m_row][m_col]);
      mag = iabs(gx) + iabs(gy);
      e = (mag > m_thr);
    end
    sbq.push_back('{sof: sof, e: e, mag: (m_mode ? mag : 0)});
    m_col++;
    if (m_col == W) begin
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end
    i_valid = 1'b1;
    i_sof = sof;
    i_data = DW'(data);
    i_threshold = MW'(thr);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_sof = 1'b0;
    for (int k = 0; k < 20 && sbq.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("drain_pending", sbq.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Send npix pixels of a frame; thr_sof goes with the first pixel, thr_rest after.
  task automatic runFrame(input int kind, input int thr_sof, input int thr_rest,
                          input int gap, input bit use_sof, input bit mode,
                          input int npix, input bit do_drain);
    m_mode = mode;
    i_mode = mode;
    for (int idx = 0; idx < npix; idx++)
      applyStimulus(pix(kind, idx / W, idx % W), use_sof && idx == 0,
                    (idx == 0) ? thr_sof : thr_rest, gap);
    if (do_drain) drain();
  endtask

  task automatic clearStats();
    edge_cnt = 0;
    mag_max = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #23 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_o_valid", o_valid, 0);
    checkOutput("reset_o_mag", o_mag, 0);

    // Flat frame: no gradient anywhere.
    clearStats();
    runFrame(K_FLAT, 1000, 1000, 0, 1'b1, 1'b1, W*H, 1'b1);
    checkOutput("flat_edges", edge_cnt, 0);
    checkOutput("flat_max_mag", mag_max, 0);

    // Vertical step, threshold 1000: two edge columns on rows 2..5.
    clearStats();
    runFrame(K_STEP, 1000, 1000, 0, 1'b1, 1'b1, W*H, 1'b1);
    checkOutput("step_edges", edge_cnt, 8);
    checkOutput("step_max_mag", mag_max, 1020);

    // Strict compare at threshold 1020.
    clearStats();
    runFrame(K_STEP, 1020, 1020, 0, 1'b1, 1'b1, W*H, 1'b1);
    checkOutput("strict_edges", edge_cnt, 0);

    // Mid-frame threshold change is ignored until the next sof.
    clearStats();
    runFrame(K_STEP, 1000, 1100, 0, 1'b1, 1'b1, W*H, 1'b1);
    checkOutput("midthr_edges", edge_cnt, 8);
    clearStats();
    runFrame(K_STEP, 1100, 1100, 0, 1'b1, 1'b1, W*H, 1'b1);
    checkOutput("newthr_edges", edge_cnt, 0);

    // Binary mode: magnitude forced to zero, edges unchanged.
    clearStats();
    runFrame(K_STEP, 1000, 1000, 0, 1'b1, 1'b0, W*H, 1'b1);
    checkOutput("mode0_edges", edge_cnt, 8);
    checkOutput("mode0_max_mag", mag_max, 0);

    // Step image with ~30% idle cycles.
    clearStats();
    runFrame(K_STEP, 1000, 1000, 30, 1'b1, 1'b1, W*H, 1'b1);
    checkOutput("gap_edges", edge_cnt, 8);
    checkOutput("gap_max_mag", mag_max, 1020);

    // Mid-frame sof at the fifth pixel of row 3, then a full frame.
    runFrame(K_STEP, 1000, 1000, 0, 1'b1, 1'b1, 3*W + 4, 1'b0);
    clearStats();
    runFrame(K_STEP, 1000, 1000, 10, 1'b1, 1'b1, W*H, 1'b1);
    checkOutput("resync_edges", edge_cnt, 8);

    // Asynchronous reset mid-frame after loading a high threshold.
    runFrame(K_STEP, 1100, 1100, 0, 1'b1, 1'b1, 20, 1'b0);
    i_valid = 1'b0;
    i_sof = 1'b0;
    #3 reset = 1'b1;
    sbq.delete();
    last_e = 0;
    last_mag = 0;
    #4;
    checkOutput("rst_o_valid", o_valid, 0);
    checkOutput("rst_o_sof", o_sof, 0);
    checkOutput("rst_o_edge", o_edge, 0);
    checkOutput("rst_o_mag", o_mag, 0);
    @(posedge clk);
    #3 reset = 1'b0;
    m_col = 0;
    m_row = 0;
    m_thr = TDEF;
    @(posedge clk); #1;
    clearStats();
    runFrame(K_STEP, 1100, 1100, 0, 1'b0, 1'b1, W*H, 1'b1);
    checkOutput("post_reset_edges", edge_cnt, 8);
    checkOutput("post_reset_max_mag", mag_max, 1020);

    // Random images, thresholds, modes and gaps against the model.
    for (int f = 0; f < 6; f++) begin
      int t0;
      t0 = int'($urandom_range(1200));
      runFrame(K_RAND, t0, (f % 2 == 0) ? t0 : int'($urandom_range(2047)),
               int'($urandom_range(40)), 1'b1, 1'($urandom_range(1)), W*H, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
